// File: rtl/gomoku_win_scanner.sv
`default_nettype none
// ============================================================================
// Module      : gomoku_win_scanner
// Description : Sequential win detector. On start it snapshots the player's
//               stone map, then walks outward from the placed stone along the
//               four line directions, one cell per clock, looking for an
//               unbroken run of at least WIN_LEN stones.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               i_start    - scan request, accepted only in IDLE
//               i_row      - row of placed stone (0 = top)
//               i_col      - column of placed stone (0 = left)
//               i_board    - player stone map, bit row*BOARD_N+col
//               o_busy     - high while probing
//               o_done     - one-cycle pulse when the result is valid
//               o_win      - run >= WIN_LEN found
//               o_win_dir  - 0 horiz, 1 vert, 2 down-right, 3 down-left
//               o_run_len  - winning run length, or longest run (capped)
// Revision    : 1.0 - initial release
// ============================================================================
module gomoku_win_scanner #(
  parameter int BOARD_N = 15,
  parameter int WIN_LEN = 5,
  parameter int COORD_W = 4,
  parameter int CNT_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [COORD_W-1:0]         i_row,
  input  logic [COORD_W-1:0]         i_col,
  input  logic [BOARD_N*BOARD_N-1:0] i_board,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_win,
  output logic [1:0]                 o_win_dir,
  output logic [CNT_W-1:0]           o_run_len
);

  localparam int c_CELLS = BOARD_N * BOARD_N;
  localparam int c_IDX_W = (c_CELLS > 1) ? $clog2(c_CELLS) : 1;
  localparam int c_CW1   = COORD_W + 1;

  // Cursor coordinates carry an extra top bit so that stepping past either
  // board edge (to -1 or to BOARD_N) is detectable.
  localparam logic [COORD_W:0] c_N       = c_CW1'(BOARD_N);
  localparam logic [COORD_W:0] c_P1      = {{COORD_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_WIN     = CNT_W'(WIN_LEN);
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_PROBE  = 2'd1;
  localparam logic [1:0] c_REPORT = 2'd2;

  logic [1:0]         r_state;
  logic [c_CELLS-1:0] r_snap;
  logic [COORD_W-1:0] r_org_row;
  logic [COORD_W-1:0] r_org_col;
  logic [COORD_W:0]   r_cur_row;
  logic [COORD_W:0]   r_cur_col;
  logic [1:0]         r_dir;
  logic               r_side;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_best;
  logic               r_win;
  logic [1:0]         r_win_dir;
  logic [CNT_W-1:0]   r_run_len;

  // Row delta per direction: 0 for horizontal, +1 otherwise.
  function automatic logic [COORD_W:0] f_dr(input logic [1:0] d);
    return (d == 2'd0) ? '0 : c_P1;
  endfunction

  // Column delta per direction, two's complement in COORD_W+1 bits.
  function automatic logic [COORD_W:0] f_dc(input logic [1:0] d);
    logic [COORD_W:0] v;
    case (d)
      2'd0, 2'd2: v = c_P1;
      2'd1:       v = '0;
      default:    v = '1;
    endcase
    return v;
  endfunction

  // Origin validity is judged on the live inputs, which are what the
  // snapshot will hold after this edge.
  logic [c_IDX_W-1:0] w_org_idx;
  logic               w_org_ok;
  assign w_org_idx = c_IDX_W'(i_row) * c_IDX_W'(BOARD_N) + c_IDX_W'(i_col);
  assign w_org_ok  = ({1'b0, i_row} < c_N) && ({1'b0, i_col} < c_N) &&
                     i_board[w_org_idx];

  logic               w_cur_in;
  logic [c_IDX_W-1:0] w_cur_idx;
  logic               w_hit;
  assign w_cur_in  = !r_cur_row[COORD_W] && !r_cur_col[COORD_W] &&
                     (r_cur_row < c_N) && (r_cur_col < c_N);
  assign w_cur_idx = c_IDX_W'(r_cur_row[COORD_W-1:0]) * c_IDX_W'(BOARD_N) +
                     c_IDX_W'(r_cur_col[COORD_W-1:0]);
  // The snapshot read is only meaningful in bounds; the AND masks the rest.
  assign w_hit     = w_cur_in && r_snap[w_cur_idx];

  logic [COORD_W:0] w_dr;
  logic [COORD_W:0] w_dc;
  logic [COORD_W:0] w_dr_nx;
  logic [COORD_W:0] w_dc_nx;
  logic [COORD_W:0] w_step_r;
  logic [COORD_W:0] w_step_c;
  logic [COORD_W:0] w_org_r;
  logic [COORD_W:0] w_org_c;
  logic [1:0]       w_dir_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_best_nx;

  assign w_dir_nx  = r_dir + 2'd1;
  assign w_dr      = f_dr(r_dir);
  assign w_dc      = f_dc(r_dir);
  assign w_dr_nx   = f_dr(w_dir_nx);
  assign w_dc_nx   = f_dc(w_dir_nx);
  assign w_step_r  = r_side ? ('0 - w_dr) : w_dr;
  assign w_step_c  = r_side ? ('0 - w_dc) : w_dc;
  assign w_org_r   = {1'b0, r_org_row};
  assign w_org_c   = {1'b0, r_org_col};
  // cnt never exceeds WIN_LEN-1 before the increment, so no overflow.
  assign w_cnt_nx  = r_cnt + c_CNT_ONE;
  assign w_best_nx = (r_cnt > r_best) ? r_cnt : r_best;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_snap    <= '0;
      r_org_row <= '0;
      r_org_col <= '0;
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_dir     <= 2'd0;
      r_side    <= 1'b0;
      r_cnt     <= '0;
      r_best    <= '0;
      r_win     <= 1'b0;
      r_win_dir <= 2'd0;
      r_run_len <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_start) begin
            r_snap    <= i_board;
            r_org_row <= i_row;
            r_org_col <= i_col;
            r_dir     <= 2'd0;
            r_side    <= 1'b0;
            r_cnt     <= c_CNT_ONE;
            r_best    <= c_CNT_ONE;
            r_cur_row <= {1'b0, i_row};
            r_cur_col <= {1'b0, i_col} + c_P1;
            r_win     <= 1'b0;
            if (w_org_ok) begin
              r_state <= c_PROBE;
            end else begin
              r_run_len <= '0;
              r_state   <= c_REPORT;
            end
          end
        end

        c_PROBE: begin
          if (w_hit) begin
            if (w_cnt_nx >= c_WIN) begin
              r_win     <= 1'b1;
              r_win_dir <= r_dir;
              r_run_len <= c_WIN;
              r_state   <= c_REPORT;
            end else begin
              r_cnt     <= w_cnt_nx;
              r_cur_row <= r_cur_row + w_step_r;
              r_cur_col <= r_cur_col + w_step_c;
            end
          end else if (!r_side) begin
            // Positive side exhausted: restart from the origin going back.
            r_side    <= 1'b1;
            r_cur_row <= w_org_r - w_dr;
            r_cur_col <= w_org_c - w_dc;
          end else begin
            r_best <= w_best_nx;
            if (r_dir == 2'd3) begin
              r_run_len <= w_best_nx;
              r_state   <= c_REPORT;
            end else begin
              r_dir     <= w_dir_nx;
              r_side    <= 1'b0;
              r_cnt     <= c_CNT_ONE;
              r_cur_row <= w_org_r + w_dr_nx;
              r_cur_col <= w_org_c + w_dc_nx;
            end
          end
        end

        c_REPORT: begin
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign o_busy    = (r_state == c_PROBE);
  assign o_done    = (r_state == c_REPORT);
  assign o_win     = r_win;
  assign o_win_dir = r_win_dir;
  assign o_run_len = r_run_len;

endmodule
`default_nettype wire
